branch_resolve_ctrl: RTL

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/ariane_pkg.sv | 25 ++
 rtl/branch_resolve_ctrl_sat_counter.sv | 31 +++
 rtl/branch_resolve_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the branch resolution controller.
//   branchpredict_t : resolution record from the branch unit, also the
//                     registered predictor (BTB) update format.
//   br_state_e      : resolution controller FSM states.
package ariane_pkg;

  // Default depth of in-flight unresolved control-flow instructions.
  localparam int unsigned NR_UNRESOLVED_BRANCHES = 1;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    logic        clear;
  } branchpredict_t;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_FLUSH,
    BR_REDIRECT
  } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (count to 0)
//   inc_i   : increment request; ignored once the counter is all ones
//   clear_i : synchronous clear, wins over inc_i
//   count_o : current count
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: tracks unresolved control-flow instructions,
// turns mispredicts into a one-cycle pipeline flush followed by a frontend
// redirect handshake, and emits registered predictor updates.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   flush_i              : global flush, overrides everything
//   issue_branch_i       : ID issues a control-flow instruction
//   issue_ready_o        : another control-flow instruction may issue
//   resolve_i            : resolve strobe, record on resolved_branch_i
//   redirect_valid_o/redirect_ready_i/redirect_pc_o : frontend redirect
//   flush_unissued_o/flush_ex_o : kill younger instructions in ID / EX
//   btb_update_o         : accepted resolution, one cycle later
//   outstanding_o        : unresolved in-flight count
//   mispredict_cnt_o     : saturating mispredict counter
// CNT_W must satisfy 2**CNT_W > NR_UNRESOLVED.
module branch_resolve_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned NR_UNRESOLVED = NR_UNRESOLVED_BRANCHES,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             issue_branch_i,
  output logic             issue_ready_o,
  input  logic             resolve_i,
  input  branchpredict_t   resolved_branch_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [63:0]      redirect_pc_o,
  output logic             flush_unissued_o,
  output logic             flush_ex_o,
  output branchpredict_t   btb_update_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic [31:0]      mispredict_cnt_o
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(NR_UNRESOLVED);

  br_state_e      r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]    r_pc;
  branchpredict_t r_btb;

  logic w_accept, w_mispredict, w_dec, w_inc;

  // Resolves outside IDLE belong to younger instructions being killed.
  assign w_accept     = resolve_i && (r_state == BR_IDLE) && !flush_i;
  // A clear (aliasing / non-branch hit) is recovered like a mispredict.
  assign w_mispredict = w_accept && (resolved_branch_i.is_mispredict || resolved_branch_i.clear);
  assign w_dec        = w_accept && !resolved_branch_i.clear;
  assign w_inc        = issue_branch_i && issue_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= BR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    redirect_valid_o = 1'b0;
    flush_unissued_o = 1'b0;
    flush_ex_o       = 1'b0;
    issue_ready_o    = 1'b0;
    unique case (r_state)
      BR_IDLE: begin
        issue_ready_o = (r_cnt < LP_MAX);
        if (w_mispredict) w_state_next = BR_FLUSH;
      end
      BR_FLUSH: begin
        redirect_valid_o = 1'b1;
        flush_unissued_o = 1'b1;
        flush_ex_o       = 1'b1;
        w_state_next     = redirect_ready_i ? BR_IDLE : BR_REDIRECT;
      end
      BR_REDIRECT: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) w_state_next = BR_IDLE;
      end
      default: w_state_next = BR_IDLE;
    endcase
    if (flush_i) w_state_next = BR_IDLE;
  end

  // Simultaneous issue and decrement cancel out, including at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (flush_i || (r_state == BR_FLUSH)) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dec && !w_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc  <= '0;
      r_btb <= '0;
    end else begin
      if (w_mispredict) r_pc <= resolved_branch_i.target_address;
      if (w_accept) begin
        r_btb       <= resolved_branch_i;
        r_btb.valid <= 1'b1;
      end else begin
        r_btb <= '0;
      end
    end
  end

  sat_counter #(
    .WIDTH(32)
  ) u_mispredict_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_mispredict),
    .clear_i (1'b0),
    .count_o (mispredict_cnt_o)
  );

  assign redirect_pc_o = r_pc;
  assign btb_update_o  = r_btb;
  assign outstanding_o = r_cnt;

endmodule
